// File: rtl/joy_db15_tx_pkg.sv
// Shared constants for the DB15 joystick shift-chain emulator:
// default player width, button indices, synchroniser and deglitch depths.
package joy_db15_pkg;

  localparam int PLAYER_BITS_DEF = 12;

  localparam int BTN_R  = 0;
  localparam int BTN_L  = 1;
  localparam int BTN_D  = 2;
  localparam int BTN_U  = 3;
  localparam int BTN_F1 = 4;
  localparam int BTN_F2 = 5;
  localparam int BTN_F3 = 6;
  localparam int BTN_F4 = 7;

  localparam int SYNC_DEPTH     = 2;
  localparam int DEGLITCH_DEPTH = 2;

endpackage

// File: rtl/joy_db15_tx_if.sv
// DB15 wire bundle between the reader (master) and the emulated
// adapter (slave): joy_clk, joy_load driven by reader, joy_data back.
interface joy_db15_tx_if;

  logic joy_clk;
  logic joy_load;
  logic joy_data;

  modport master (
    output joy_clk,
    output joy_load,
    input  joy_data
  );

  modport slave (
    input  joy_clk,
    input  joy_load,
    output joy_data
  );

endinterface

// File: rtl/joy_db15_tx_sync.sv
// Synchroniser + optional deglitch (JOY_DB15_TX_DEGLITCH_EN) + edge detect.
// Ports: clk, reset_n, din (async) -> level, rise, fall (clk domain).
module joy_db15_tx_sync
  import joy_db15_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] chain;
  logic                  s;
  logic                  held;
  logic                  lvl;

  assign s = chain[SYNC_DEPTH-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain <= {SYNC_DEPTH{RESET_VAL}};
      held  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_DEPTH-2:0], din};
      held  <= lvl;
    end
  end

`ifdef JOY_DB15_TX_DEGLITCH_EN
  // Accept a new level only once it has matched the history flops.
  logic [DEGLITCH_DEPTH-2:0] hist;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist <= {(DEGLITCH_DEPTH-1){RESET_VAL}};
    end else if (DEGLITCH_DEPTH > 2) begin
      hist <= {hist, s};
    end else begin
      hist <= {(DEGLITCH_DEPTH-1){s}};
    end
  end

  always_comb begin
    lvl = held;
    if (hist == {(DEGLITCH_DEPTH-1){s}})
      lvl = s;
  end
`else
  assign lvl = s;
`endif

  assign level = lvl;
  assign rise  = lvl & ~held;
  assign fall  = ~lvl & held;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 adapter emulator: captures two players on joy_load low, shifts
// one bit per joy_clk rise onto joy_data (active-low). Reports bit_cnt,
// frame_done pulse and sticky overrun. Option: JOY_DB15_TX_DEGLITCH_EN.
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int PLAYER_BITS = PLAYER_BITS_DEF,
  localparam int FRAME_BITS = 2 * PLAYER_BITS,
  localparam int CW         = $clog2(FRAME_BITS + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  joy_db15_tx_if.slave           bus,
  input  logic [PLAYER_BITS-1:0] joystick1,
  input  logic [PLAYER_BITS-1:0] joystick2,
  output logic [CW-1:0]          bit_cnt,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS);

  logic                  clk_lvl;
  logic                  clk_rise;
  logic                  clk_fall;
  logic                  ld_lvl;
  logic                  ld_rise;
  logic                  ld_fall;
  logic                  shift;
  logic [FRAME_BITS-1:0] sr;
  logic                  unused_edges;

  joy_db15_tx_sync #(.RESET_VAL(1'b0)) u_clk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (bus.joy_clk),
    .level   (clk_lvl),
    .rise    (clk_rise),
    .fall    (clk_fall)
  );

  joy_db15_tx_sync #(.RESET_VAL(1'b1)) u_ld_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (bus.joy_load),
    .level   (ld_lvl),
    .rise    (ld_rise),
    .fall    (ld_fall)
  );

  assign unused_edges = clk_lvl ^ clk_fall ^ ld_fall;

  // A clock edge seen together with the load release would skip bit 0.
  assign shift = clk_rise & ld_lvl & ~ld_rise;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr         <= '1;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!ld_lvl) begin
        sr      <= ~{joystick2, joystick1};
        bit_cnt <= '0;
        overrun <= 1'b0;
      end else if (shift) begin
        sr <= {1'b1, sr[FRAME_BITS-1:1]};
        if (bit_cnt < LAST) begin
          bit_cnt    <= bit_cnt + 1'b1;
          frame_done <= (bit_cnt == LAST - 1'b1);
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign bus.joy_data = sr[0];

endmodule

// File: tb/tb_joy_db15_tx.sv
// Self-checking bench for joy_db15_tx: vector table of full frames
// plus directed overrun, abort, coincident-edge, latency and reset cases.
module tb_joy_db15_tx;

  logic        clk;
  logic        reset_n;
  logic [11:0] joystick1;
  logic [11:0] joystick2;
  logic [4:0]  bit_cnt;
  logic        frame_done;
  logic        overrun;

  joy_db15_tx_if bus();

  joy_db15_tx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .bit_cnt    (bit_cnt),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

`ifdef JOY_DB15_TX_DEGLITCH_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int fd_cnt = 0;

  always @(negedge clk)
    if (frame_done) fd_cnt++;

  typedef struct {
    logic [11:0] j1;
    logic [11:0] j2;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    bus.joy_clk = 1'b1;
    cyc(5);
    bus.joy_clk = 1'b0;
    cyc(5);
  endtask

  task automatic load();
    bus.joy_load = 1'b0;
    cyc(6);
    bus.joy_load = 1'b1;
    cyc(6);
  endtask

  task automatic read_frame(output logic [23:0] cap);
    for (int i = 0; i < 24; i++) begin
      cap[i] = bus.joy_data;
      pulse();
    end
  endtask

  logic [23:0] cap;
  logic [4:0]  c0;

  initial begin
    vecs[0] = '{12'h001, 12'h000, 24'hFFFFFE};
    vecs[1] = '{12'hA5A, 12'h3C3, 24'hC3C5A5};
    vecs[2] = '{12'hFFF, 12'hFFF, 24'h000000};
    vecs[3] = '{12'h000, 12'h800, 24'h7FFFFF};

    reset_n      = 1'b0;
    bus.joy_clk  = 1'b0;
    bus.joy_load = 1'b1;
    joystick1    = '0;
    joystick2    = '0;
    cyc(3);
    chk("rst_data", 32'(bus.joy_data), 32'd1);
    chk("rst_cnt", 32'(bit_cnt), 32'd0);
    reset_n = 1'b1;
    cyc(8);
    chk("idle_data", 32'(bus.joy_data), 32'd1);
    chk("idle_cnt", 32'(bit_cnt), 32'd0);
    chk("idle_fd", 32'(fd_cnt), 32'd0);
    chk("idle_ov", 32'(overrun), 32'd0);

    for (int v = 0; v < 4; v++) begin
      joystick1 = vecs[v].j1;
      joystick2 = vecs[v].j2;
      load();
      fd_cnt = 0;
      read_frame(cap);
      chk($sformatf("v%0d_frame", v), 32'(cap), 32'(vecs[v].exp));
      chk($sformatf("v%0d_cnt", v), 32'(bit_cnt), 32'd24);
      chk($sformatf("v%0d_fd", v), 32'(fd_cnt), 32'd1);
      chk($sformatf("v%0d_ov", v), 32'(overrun), 32'd0);
      chk($sformatf("v%0d_tail", v), 32'(bus.joy_data), 32'd1);
    end

    joystick1 = 12'h123;
    joystick2 = 12'h456;
    load();
    for (int i = 0; i < 26; i++) pulse();
    chk("ovr_cnt", 32'(bit_cnt), 32'd24);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_data", 32'(bus.joy_data), 32'd1);
    load();
    chk("ovr_clear", 32'(overrun), 32'd0);

    joystick1 = 12'h000;
    joystick2 = 12'h000;
    load();
    for (int i = 0; i < 5; i++) pulse();
    chk("abort_cnt5", 32'(bit_cnt), 32'd5);
    joystick1 = 12'h002;
    joystick2 = 12'h001;
    bus.joy_load = 1'b0;
    cyc(6);
    chk("abort_cnt0", 32'(bit_cnt), 32'd0);
    chk("abort_bit0", 32'(bus.joy_data), 32'd1);
    bus.joy_load = 1'b1;
    cyc(6);
    joystick1 = 12'hFFF;
    read_frame(cap);
    chk("abort_frame", 32'(cap), 32'h00FFEFFD);

    joystick1 = 12'h001;
    joystick2 = 12'h000;
    bus.joy_load = 1'b0;
    cyc(6);
    bus.joy_load = 1'b1;
    bus.joy_clk  = 1'b1;
    cyc(6);
    chk("coinc_cnt", 32'(bit_cnt), 32'd0);
    chk("coinc_bit0", 32'(bus.joy_data), 32'd0);
    bus.joy_clk = 1'b0;
    cyc(5);
    pulse();
    chk("coinc_cnt1", 32'(bit_cnt), 32'd1);
    chk("coinc_bit1", 32'(bus.joy_data), 32'd1);

    c0 = bit_cnt;
    bus.joy_clk = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("lat_early", 32'(bit_cnt), 32'(c0));
    @(posedge clk);
    #1;
    chk("lat_hit", 32'(bit_cnt), 32'(c0 + 5'd1));
    cyc(4);
    bus.joy_clk = 1'b0;
    cyc(5);

`ifdef JOY_DB15_TX_DEGLITCH_EN
    c0 = bit_cnt;
    bus.joy_clk = 1'b1;
    cyc(1);
    bus.joy_clk = 1'b0;
    cyc(8);
    chk("glitch_cnt", 32'(bit_cnt), 32'(c0));
`endif

    load();
    fd_cnt = 0;
    for (int i = 0; i < 10; i++) pulse();
    reset_n = 1'b0;
    cyc(1);
    chk("mid_rst_cnt", 32'(bit_cnt), 32'd0);
    chk("mid_rst_data", 32'(bus.joy_data), 32'd1);
    reset_n = 1'b1;
    cyc(10);
    chk("mid_rst_fd", 32'(fd_cnt), 32'd0);
    chk("mid_rst_ov", 32'(overrun), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
